// File: rtl/wakeup_irq_ctrl.sv
// Wakeup/interrupt controller for the 20-bit timer counter: drives en/clr, detects
// match or wakeup events and raises a level irq with ack handshake and miss counting.
module wakeup_irq_ctrl #(
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned MISS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_mode,
  input  logic              cmp_we,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic [CNT_W-1:0]  cnt_val,
  input  logic              cnt_wakeup,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              irq,
  input  logic              irq_ack,
  output logic [MISS_W-1:0] miss_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_ACK
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cmp_reg;
  logic [MISS_W-1:0] miss_nxt;
  logic              irq_nxt;
  logic              cnt_en_nxt;
  logic              cnt_clr_nxt;
  logic              busy_nxt;
  logic              evt;

  // Events only count while the counter is actually running.
  assign evt = cnt_en & ((cnt_val == cmp_reg) | cnt_wakeup);

  // Match value; a zero write would make ARMED unreachable, so it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_reg <= '0;
    end else if (cmp_we && (cmp_val != '0)) begin
      cmp_reg <= cmp_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      miss_cnt <= '0;
      irq      <= 1'b0;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_nxt;
      irq      <= irq_nxt;
      cnt_en   <= cnt_en_nxt;
      cnt_clr  <= cnt_clr_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next state, miss counter and the output values for the next state.
  always_comb begin
    state_nxt   = state;
    miss_nxt    = miss_cnt;
    irq_nxt     = 1'b0;
    cnt_en_nxt  = 1'b0;
    cnt_clr_nxt = 1'b1;
    busy_nxt    = 1'b0;

    if (!cfg_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmp_reg != '0) begin
            state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (evt) begin
            state_nxt = ST_FIRE;
          end
        end
        ST_FIRE: begin
          state_nxt = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (irq_ack) begin
            miss_nxt = '0;
            if (evt) begin
              state_nxt = ST_FIRE;
            end else if (cfg_mode) begin
              state_nxt = ST_ARMED;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (evt && (miss_cnt != MISS_MAX)) begin
            miss_nxt = miss_cnt + MISS_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    case (state_nxt)
      ST_ARMED: begin
        cnt_en_nxt  = 1'b1;
        cnt_clr_nxt = 1'b0;
        busy_nxt    = 1'b1;
      end
      ST_FIRE: begin
        irq_nxt     = 1'b1;
        cnt_en_nxt  = cfg_mode;
        cnt_clr_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      ST_WAIT_ACK: begin
        irq_nxt     = 1'b1;
        cnt_en_nxt  = cfg_mode;
        cnt_clr_nxt = 1'b0;
        busy_nxt    = 1'b1;
      end
      default: begin
        irq_nxt     = 1'b0;
        cnt_en_nxt  = 1'b0;
        cnt_clr_nxt = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wakeup_irq_ctrl.sv
// Bench for wakeup_irq_ctrl: vector table, directed corner sequences and a
// randomized run against a rule-level reference model, with a simple counter model.
module tb_wakeup_irq_ctrl;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned MISS_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_en;
  logic              cfg_mode;
  logic              cmp_we;
  logic [CNT_W-1:0]  cmp_val;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_wakeup;
  logic              cnt_en;
  logic              cnt_clr;
  logic              irq;
  logic              irq_ack;
  logic [MISS_W-1:0] miss_cnt;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wakeup_irq_ctrl #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cmp_we(cmp_we), .cmp_val(cmp_val), .cnt_val(cnt_val), .cnt_wakeup(cnt_wakeup),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .irq(irq), .irq_ack(irq_ack),
    .miss_cnt(miss_cnt), .busy(busy)
  );

  // Timer counter the controller drives: clear wins, otherwise count when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_val <= '0;
    else if (cnt_clr)  cnt_val <= '0;
    else if (cnt_en)   cnt_val <= cnt_val + 20'd1;
  end

  // Reference model: phase 0 idle, 1 armed, 2 fire, 3 waiting for ack.
  int         m_st;
  int         n_st;
  logic [19:0] m_cmp;
  logic [3:0]  m_miss;
  logic [3:0]  n_miss;
  logic        m_mode_q;
  logic        m_en;
  logic        m_ev;

  always_comb begin
    m_en   = (m_st == 1) || ((m_st >= 2) && m_mode_q);
    m_ev   = m_en && ((cnt_val == m_cmp) || cnt_wakeup);
    n_st   = m_st;
    n_miss = m_miss;
    if (!cfg_en)           n_st = 0;
    else if (m_st == 0)    n_st = (m_cmp != 20'd0) ? 1 : 0;
    else if (m_st == 1)    n_st = m_ev ? 2 : 1;
    else if (m_st == 2)    n_st = 3;
    else if (irq_ack) begin
      n_miss = 4'd0;
      n_st   = m_ev ? 2 : (cfg_mode ? 1 : 0);
    end else if (m_ev && (m_miss != 4'd15)) begin
      n_miss = m_miss + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st     <= 0;
      m_cmp    <= '0;
      m_miss   <= '0;
      m_mode_q <= 1'b0;
    end else begin
      m_st     <= n_st;
      m_miss   <= n_miss;
      m_mode_q <= cfg_mode;
      if (cmp_we && (cmp_val != 20'd0)) m_cmp <= cmp_val;
    end
  end

  function automatic int exp_o(input int i, input int e, input int c, input int b, input int m);
    return (i << 7) | (e << 6) | (c << 5) | (b << 4) | (m & 15);
  endfunction

  function automatic int outs();
    return 32'({irq, cnt_en, cnt_clr, busy, miss_cnt});
  endfunction

  function automatic int model_outs();
    return exp_o(int'(m_st >= 2), int'(m_en), int'(m_st == 0 || m_st == 2), int'(m_st != 0), int'(m_miss));
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_en = 1'b0; cfg_mode = 1'b0; cmp_we = 1'b0; cmp_val = '0;
    cnt_wakeup = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic program_cmp(input int v, input int mode);
    cmp_we = 1'b1; cmp_val = 20'(v); cfg_mode = 1'(mode); cfg_en = 1'b1;
    tick();
    cmp_we = 1'b0; cmp_val = '0;
  endtask

  typedef struct {
    int en, mode, we, val, wk, ack;
    int irq, cen, clr, busy, miss;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int found, last_fire, maxv, fires, ack_pend;

    tbl = '{
      '{1,0,0,0,0,0,    0,0,1,0,0},
      '{1,0,1,0,0,0,    0,0,1,0,0},
      '{1,0,1,1000,0,0, 0,0,1,0,0},
      '{1,0,0,0,0,0,    0,1,0,1,0},
      '{1,0,0,0,1,0,    1,0,1,1,0},
      '{1,0,0,0,0,0,    1,0,0,1,0},
      '{1,0,0,0,1,0,    1,0,0,1,0},
      '{1,0,0,0,0,1,    0,0,1,0,0},
      '{1,1,0,0,0,0,    0,1,0,1,0},
      '{1,1,0,0,0,1,    0,1,0,1,0},
      '{1,1,0,0,1,0,    1,1,1,1,0},
      '{1,1,0,0,1,0,    1,1,0,1,0},
      '{1,1,0,0,1,0,    1,1,0,1,1},
      '{1,1,0,0,1,0,    1,1,0,1,2},
      '{1,1,0,0,1,1,    1,1,1,1,0},
      '{1,1,0,0,0,0,    1,1,0,1,0},
      '{1,1,0,0,1,0,    1,1,0,1,1},
      '{0,1,0,0,0,0,    0,0,1,0,1},
      '{0,1,0,0,0,1,    0,0,1,0,1},
      '{1,1,1,0,0,0,    0,1,0,1,1},
      '{1,1,0,0,0,0,    0,1,0,1,1}
    };

    // Reset values, then idle with nothing configured.
    clear_inputs();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), exp_o(0,0,1,0,0));
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_no_cfg", outs(), exp_o(0,0,1,0,0));

    for (int i = 0; i < 21; i++) begin
      cfg_en = 1'(tbl[i].en); cfg_mode = 1'(tbl[i].mode);
      cmp_we = 1'(tbl[i].we); cmp_val = 20'(tbl[i].val);
      cnt_wakeup = 1'(tbl[i].wk); irq_ack = 1'(tbl[i].ack);
      tick();
      chk($sformatf("vec%0d", i), outs(),
          exp_o(tbl[i].irq, tbl[i].cen, tbl[i].clr, tbl[i].busy, tbl[i].miss));
    end

    // One-shot: irq one cycle after cnt_val hits the match value.
    do_reset();
    program_cmp(10, 0);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (cnt_val == 20'd10 && !irq) found = 1;
      else tick();
    end
    chk("os_match_seen", found, 1);
    tick();
    chk("os_fire", outs(), exp_o(1,0,1,1,0));
    tick();
    chk("os_cnt_zero", int'(cnt_val), 0);
    chk("os_wait", outs(), exp_o(1,0,0,1,0));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("os_ack", outs(), exp_o(0,0,1,0,0));

    // Periodic with ack one cycle after each irq: period cmp+2.
    do_reset();
    program_cmp(5, 1);
    last_fire = -1; maxv = 0; fires = 0; ack_pend = 0;
    for (int c = 0; c < 60; c++) begin
      if (int'(cnt_val) > maxv) maxv = int'(cnt_val);
      irq_ack = 1'(ack_pend);
      ack_pend = 0;
      if (irq && cnt_clr) begin
        if (last_fire >= 0) chk("per_period", c - last_fire, 7);
        last_fire = c;
        fires++;
        ack_pend = 1;
      end
      tick();
    end
    irq_ack = 1'b0;
    chk("per_fire_count_ge5", int'(fires >= 5), 1);
    chk("per_max_cnt", maxv, 6);
    chk("per_miss_zero", int'(miss_cnt), 0);

    // Missed events saturate while irq is unacked.
    do_reset();
    program_cmp(3, 1);
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (irq) found = 1;
      else tick();
    end
    chk("miss_first_irq", found, 1);
    for (int c = 0; c < 60; c++) begin
      cnt_wakeup = 1'(c % 3 == 0);
      tick();
    end
    cnt_wakeup = 1'b0;
    chk("miss_saturated", outs(), exp_o(1,1,0,1,15));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("miss_ack_clears", outs(), exp_o(0,1,0,1,0));

    // Ack together with an event refires with no irq gap.
    cnt_wakeup = 1'b1;
    tick();
    cnt_wakeup = 1'b0;
    chk("sim_fire", outs(), exp_o(1,1,1,1,0));
    tick();
    chk("sim_wait", outs(), exp_o(1,1,0,1,0));
    cnt_wakeup = 1'b1; irq_ack = 1'b1;
    tick();
    cnt_wakeup = 1'b0; irq_ack = 1'b0;
    chk("sim_refire", outs(), exp_o(1,1,1,1,0));
    tick();
    chk("sim_wait2", outs(), exp_o(1,1,0,1,0));

    // Disable mid-wait, then reset in the middle of a FIRE cycle.
    cfg_en = 1'b0;
    tick();
    chk("abort_wait", outs(), exp_o(0,0,1,0,0));
    cfg_en = 1'b1;
    tick();
    chk("rearm", outs(), exp_o(0,1,0,1,0));
    cnt_wakeup = 1'b1;
    tick();
    cnt_wakeup = 1'b0;
    chk("pre_rst_fire", outs(), exp_o(1,1,1,1,0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_fire", outs(), exp_o(0,0,1,0,0));
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", outs(), exp_o(0,0,1,0,0));

    // Randomized run against the reference model.
    do_reset();
    cfg_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cfg_en     = 1'($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) cfg_mode = ~cfg_mode;
      cmp_we     = 1'($urandom_range(0, 29) == 0);
      cmp_val    = 20'($urandom_range(0, 12));
      cnt_wakeup = 1'($urandom_range(0, 14) == 0);
      irq_ack    = 1'($urandom_range(0, 5) == 0);
      tick();
      chk("model", outs(), model_outs());
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
